uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between two byte FIFOs: ch0 carries command

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART TX between two byte FIFOs
// Optional mid-packet starvation abort with padding: define ARB_TIMEOUT_EN
module uart_tx_arbiter #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    CNT_W          = 5,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] PAD_BYTE       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_W-1:0]      ch0_count,
    input  logic [DATA_WIDTH-1:0] ch0_data,
    output logic                  ch0_rd,
    input  logic [CNT_W-1:0]      ch1_count,
    input  logic [DATA_WIDTH-1:0] ch1_data,
    output logic                  ch1_rd,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  abort_err
);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_BODY, S_PAD} state_t;
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] r_stall, w_stall_next;
    logic               r_abort, w_abort_next;
`else
    typedef enum logic [1:0] {S_IDLE, S_BODY} state_t;
`endif

    state_t                r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic [1:0]            r_grant, w_grant_next;
    logic [7:0]            r_remaining, w_rem_next;
    logic                  r_last_grant, w_last_next;

    logic                  w_slot_free, w_has0, w_has1, w_gcount_nz, w_sel;
    logic                  w_pop0, w_pop1, w_load;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_slot_free = !r_tx_valid || tx_ready;
    assign w_has0      = (ch0_count != '0);
    assign w_has1      = (ch1_count != '0);
    assign w_gcount_nz = r_grant[1] ? w_has1 : w_has0;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_rem_next   = r_remaining;
        w_last_next  = r_last_grant;
        w_sel        = 1'b0;
        w_pop0       = 1'b0;
        w_pop1       = 1'b0;
        w_load       = 1'b0;
        w_load_data  = '0;
`ifdef ARB_TIMEOUT_EN
        w_stall_next = '0;
        w_abort_next = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_slot_free && (w_has0 || w_has1)) begin
                    // on a tie, serve the channel that did not go last
                    w_sel       = w_has1 && (!w_has0 || !r_last_grant);
                    w_pop0      = !w_sel;
                    w_pop1      = w_sel;
                    w_load      = 1'b1;
                    w_load_data = w_sel ? ch1_data : ch0_data;
                    w_last_next = w_sel;
                    w_rem_next  = w_load_data[7:0];
                    if (w_load_data != '0) begin
                        w_state_next = S_BODY;
                        w_grant_next = w_sel ? 2'b10 : 2'b01;
                    end
                end
            end
            S_BODY: begin
                if (w_slot_free && w_gcount_nz) begin
                    w_pop0      = r_grant[0];
                    w_pop1      = r_grant[1];
                    w_load      = 1'b1;
                    w_load_data = r_grant[1] ? ch1_data : ch0_data;
                    w_rem_next  = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        w_state_next = S_IDLE;
                        w_grant_next = 2'b00;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (!w_gcount_nz) begin
                    if (r_stall == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state_next = S_PAD;
                        w_abort_next = 1'b1;
                    end else begin
                        w_stall_next = r_stall + 1'b1;
                    end
                end else begin
                    w_stall_next = r_stall;
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            S_PAD: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_data = PAD_BYTE;
                    w_rem_next  = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        w_state_next = S_IDLE;
                        w_grant_next = 2'b00;
                    end
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_grant      <= 2'b00;
            r_remaining  <= 8'd0;
            r_last_grant <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_stall      <= '0;
            r_abort      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_remaining  <= w_rem_next;
            r_last_grant <= w_last_next;
            if (w_load) begin
                r_tx_data  <= w_load_data;
                r_tx_valid <= 1'b1;
            end else if (tx_ready) begin
                r_tx_valid <= 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            r_stall      <= w_stall_next;
            r_abort      <= w_abort_next;
`endif
        end
    end

    // pops are suppressed during reset so FIFO contents survive it
    assign ch0_rd   = w_pop0 && !rst;
    assign ch1_rd   = w_pop1 && !rst;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign grant    = r_grant;
    assign busy     = (r_state != S_IDLE);
`ifdef ARB_TIMEOUT_EN
    assign abort_err = r_abort;
`else
    assign abort_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ch0_count, ch1_count;
    logic [7:0] ch0_data, ch1_data, tx_data;
    logic       ch0_rd, ch1_rd, tx_valid, tx_ready, busy, abort_err;
    logic [1:0] grant;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] sent[$];
    logic       rdlog[$];
    int         n_abort = 0;
    int         n_pass = 0;
    int         n_checks = 0;

`ifdef ARB_TIMEOUT_EN
    localparam int STALL3 = 5;
`else
    localparam int STALL3 = 10;
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_WIDTH(8), .CNT_W(5), .TIMEOUT_CYCLES(8), .PAD_BYTE(8'h00)
    ) dut (
        .clk(clk), .rst(rst),
        .ch0_count(ch0_count), .ch0_data(ch0_data), .ch0_rd(ch0_rd),
        .ch1_count(ch1_count), .ch1_data(ch1_data), .ch1_rd(ch1_rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .busy(busy), .abort_err(abort_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic update_inputs();
        ch0_count = (q0.size() > 31) ? 5'd31 : 5'(q0.size());
        ch1_count = (q1.size() > 31) ? 5'd31 : 5'(q1.size());
        ch0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
        ch1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic push(input int ch, input int n, input logic [63:0] v);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = v[8*(n-1-i) +: 8];
            if (ch == 1) q1.push_back(b);
            else         q0.push_back(b);
        end
        update_inputs();
    endtask

    // one clock: sample strobes/handshake at negedge, model FIFO pops just after posedge
    task automatic tick();
        logic r0, r1;
        @(negedge clk);
        r0 = ch0_rd;
        r1 = ch1_rd;
        check("rd_both", {31'b0, r0 & r1}, 32'd0);
        check("rd_empty", {31'b0, (r0 && ch0_count == 0) || (r1 && ch1_count == 0)}, 32'd0);
        if (tx_valid && tx_ready) sent.push_back(tx_data);
        if (r0) rdlog.push_back(1'b0);
        if (r1) rdlog.push_back(1'b1);
        if (abort_err) n_abort++;
        @(posedge clk);
        #1;
        if (r0 && q0.size() != 0) void'(q0.pop_front());
        if (r1 && q1.size() != 0) void'(q1.pop_front());
        update_inputs();
    endtask

    task automatic clear_logs();
        sent.delete();
        rdlog.delete();
        n_abort = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic expect_bytes(input string tag, input int n, input logic [63:0] v);
        check({tag, "_len"}, 32'(sent.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < sent.size()) check(tag, {24'b0, sent[i]}, {24'b0, v[8*(n-1-i) +: 8]});
    endtask

    task automatic expect_chans(input string tag, input int n, input logic [15:0] bits);
        check({tag, "_len"}, 32'(rdlog.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < rdlog.size()) check(tag, {31'b0, rdlog[i]}, {31'b0, bits[n-1-i]});
    endtask

    initial begin
        rst = 1'b1;
        tx_ready = 1'b1;
        update_inputs();
        tick();
        tick();
        check("rst_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_data", {24'b0, tx_data}, 32'd0);
        check("rst_grant", {30'b0, grant}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_abort", {31'b0, abort_err}, 32'd0);
        check("rst_rd", {30'b0, ch0_rd, ch1_rd}, 32'd0);
        rst = 1'b0;
        clear_logs();

        // basic packet, one byte per cycle
        push(0, 3, 64'h02AABB);
        tick();
        check("t1_hdr", {24'b0, tx_data}, 32'h02);
        check("t1_hdr_valid", {31'b0, tx_valid}, 32'd1);
        check("t1_hdr_grant", {30'b0, grant}, 32'h1);
        check("t1_busy", {31'b0, busy}, 32'd1);
        tick();
        check("t1_b1", {24'b0, tx_data}, 32'hAA);
        check("t1_b1_grant", {30'b0, grant}, 32'h1);
        tick();
        check("t1_b2", {24'b0, tx_data}, 32'hBB);
        check("t1_b2_valid", {31'b0, tx_valid}, 32'd1);
        check("t1_end_grant", {30'b0, grant}, 32'h0);
        check("t1_end_busy", {31'b0, busy}, 32'd0);
        tick();
        check("t1_drain", {31'b0, tx_valid}, 32'd0);
        expect_bytes("t1_stream", 3, 64'h02AABB);
        expect_chans("t1_rd", 3, 16'b000);

        // round-robin alternation
        do_reset();
        push(0, 2, 64'h01C0);
        push(1, 2, 64'h01D0);
        repeat (6) tick();
        expect_bytes("t2a_stream", 4, 64'h01C001D0);
        expect_chans("t2a_rd", 4, 16'b0011);
        clear_logs();
        push(0, 2, 64'h01C0);
        push(1, 2, 64'h01D0);
        repeat (6) tick();
        expect_bytes("t2b_stream", 4, 64'h01C001D0);
        expect_chans("t2b_rd", 4, 16'b0011);
        clear_logs();
        push(0, 2, 64'h0000);
        push(1, 1, 64'h00);
        repeat (5) tick();
        expect_chans("t2c_rd", 3, 16'b010);
        expect_bytes("t2c_stream", 3, 64'h000000);

        // mid-packet stall blocks the other channel
        do_reset();
        push(0, 2, 64'h0311);
        push(1, 1, 64'h00);
        repeat (2 + STALL3) tick();
        check("t3_stall_busy", {31'b0, busy}, 32'd1);
        check("t3_stall_grant", {30'b0, grant}, 32'h1);
        check("t3_stall_valid", {31'b0, tx_valid}, 32'd0);
        check("t3_ch1_untouched", 32'(q1.size()), 32'd1);
        push(0, 2, 64'h2233);
        repeat (6) tick();
        expect_bytes("t3_stream", 5, 64'h0311223300);
        expect_chans("t3_rd", 5, 16'b00001);
        check("t3_end_busy", {31'b0, busy}, 32'd0);

        // backpressure holds the output and stops pops
        do_reset();
        push(0, 5, 64'h04A1A2A3A4);
        tick();
        tick();
        check("t4_pre", {24'b0, tx_data}, 32'hA1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_data", {24'b0, tx_data}, 32'hA1);
            check("t4_hold_valid", {31'b0, tx_valid}, 32'd1);
            check("t4_no_pop", 32'(q0.size()), 32'd3);
        end
        tx_ready = 1'b1;
        repeat (6) tick();
        expect_bytes("t4_stream", 5, 64'h04A1A2A3A4);

        // zero-length packet on ch1
        do_reset();
        push(1, 1, 64'h00);
        tick();
        check("t5_data", {24'b0, tx_data}, 32'h00);
        check("t5_valid", {31'b0, tx_valid}, 32'd1);
        check("t5_grant", {30'b0, grant}, 32'h0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        tick();
        expect_bytes("t5_stream", 1, 64'h00);
        expect_chans("t5_rd", 1, 16'b1);

        // reset mid-packet leaves FIFO contents alone
        do_reset();
        push(0, 4, 64'h03010203);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t6_fifo_kept", 32'(q0.size()), 32'd2);
        check("t6_valid", {31'b0, tx_valid}, 32'd0);
        check("t6_grant", {30'b0, grant}, 32'h0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        q0.delete();
        update_inputs();

        // maximum header: 256 bytes total
        do_reset();
        q0.push_back(8'hFF);
        for (int i = 0; i < 255; i++) q0.push_back(8'(i));
        update_inputs();
        repeat (260) tick();
        check("t7_len", 32'(sent.size()), 32'd256);
        if (sent.size() == 256) begin
            check("t7_first", {24'b0, sent[0]}, 32'hFF);
            check("t7_last", {24'b0, sent[255]}, 32'hFE);
        end
        check("t7_busy", {31'b0, busy}, 32'd0);
        check("t7_fifo_empty", 32'(q0.size()), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // starvation abort pads the rest of the packet
        do_reset();
        push(0, 2, 64'h04AA);
        repeat (9) tick();
        check("t8_no_abort_yet", 32'(n_abort), 32'd0);
        tick();
        check("t8_abort", {31'b0, abort_err}, 32'd1);
        repeat (6) tick();
        check("t8_abort_once", 32'(n_abort), 32'd1);
        expect_bytes("t8_stream", 5, 64'h04AA000000);
        check("t8_busy", {31'b0, busy}, 32'd0);
`else
        check("t8_abort_tied", 32'(n_abort), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
